// File: rtl/rtype_pkg.sv
// Shared encodings for the R-type execution controller: opcode/funct7 constants,
// ALU operation codes and the sequencer state type.
package rtype_pkg;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    READ   = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4
  } state_t;

endpackage

// File: rtl/rtype_op_encode.sv
// Combinational R-type classifier: flags legal RV32I R-type encodings and maps
// them to the ALU operation code. Illegal words report ADD so alu_op never floats.
module rtype_op_encode
  import rtype_pkg::*;
(
  input  logic [6:0] funct7,
  input  logic [2:0] funct3,
  input  logic [6:0] opcode,
  output logic       legal,
  output logic [3:0] alu_op
);

  always_comb begin
    legal  = 1'b0;
    alu_op = ALU_ADD;
    if (opcode == OPC_RTYPE) begin
      if (funct7 == F7_BASE) begin
        legal = 1'b1;
        case (funct3)
          3'b000:  alu_op = ALU_ADD;
          3'b001:  alu_op = ALU_SLL;
          3'b010:  alu_op = ALU_SLT;
          3'b011:  alu_op = ALU_SLTU;
          3'b100:  alu_op = ALU_XOR;
          3'b101:  alu_op = ALU_SRL;
          3'b110:  alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
      end else if (funct7 == F7_ALT) begin
        if (funct3 == 3'b000) begin
          legal  = 1'b1;
          alu_op = ALU_SUB;
        end else if (funct3 == 3'b101) begin
          legal  = 1'b1;
          alu_op = ALU_SRA;
        end
      end
    end
  end

endmodule

// File: rtl/rtype_exec_ctrl.sv
// Multi-cycle R-type sequencer: accepts one instruction, classifies it, then
// steps register read, ALU issue and write-back strobes and counts retirements.
module rtype_exec_ctrl
  import rtype_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  output logic             instr_ready,
  input  logic             flush,
  output logic             rf_rd_en,
  output logic [4:0]       rf_rs1,
  output logic [4:0]       rf_rs2,
  output logic             alu_en,
  output logic [3:0]       alu_op,
  output logic             rf_wr_en,
  output logic [4:0]       rf_rd,
  input  logic             wb_ready,
  output logic             illegal,
  output logic             busy,
  output logic [CNT_W-1:0] retired_cnt
);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] ir;
  logic        legal;
  logic [3:0]  op_dec;
  logic        rd_zero;
  logic        retire;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  rtype_op_encode u_encode (
    .funct7 (ir[31:25]),
    .funct3 (ir[14:12]),
    .opcode (ir[6:0]),
    .legal  (legal),
    .alu_op (op_dec)
  );

  assign rf_rs1  = ir[19:15];
  assign rf_rs2  = ir[24:20];
  assign rf_rd   = ir[11:7];
  assign alu_op  = op_dec;
  assign rd_zero = (ir[11:7] == 5'd0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                             ir <= '0;
    else if (state == IDLE && instr_valid) ir <= instr;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       retired_cnt <= '0;
    else if (retire) retired_cnt <= sat_inc(retired_cnt);
  end

  // flush aborts only before write-back; a write in WB always finishes
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (instr_valid) state_nxt = DECODE;
      DECODE:  state_nxt = (flush || !legal) ? IDLE : READ;
      READ:    state_nxt = flush ? IDLE : EXEC;
      EXEC:    state_nxt = flush ? IDLE : WB;
      WB:      if (rd_zero || wb_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state == IDLE) && !reset;
    busy        = (state != IDLE);
    rf_rd_en    = (state == READ);
    alu_en      = (state == EXEC);
    rf_wr_en    = (state == WB) && !rd_zero;
    illegal     = (state == DECODE) && !legal && !flush;
    retire      = (state == WB) && (rd_zero || wb_ready);
  end

endmodule

// File: doc/rtype_exec_ctrl.md
Name: rtype_exec_ctrl

Overview:
Multi-cycle sequencer for the R-type execution path. It accepts one 32-bit instruction over a valid/ready handshake and classifies it as a legal RV32I R-type op or illegal. For legal ops it steps the register-file read, ALU issue and write-back strobes in order, and it counts retired instructions. It sits between the instruction source and the decoder/register-file/ALU datapath.

Parameters:
CNT_W, 16, width of retired-instruction counter (saturating)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
instr_valid  in  1  instruction offered
instr  in  32  instruction word
instr_ready  out  1  controller can accept (high only in IDLE)
flush  in  1  synchronous abort of in-flight instruction
rf_rd_en  out  1  register-file read strobe
rf_rs1  out  5  source register 1 index
rf_rs2  out  5  source register 2 index
alu_en  out  1  ALU issue strobe
alu_op  out  4  ALU operation code (package encoding)
rf_wr_en  out  1  register-file write strobe
rf_rd  out  5  destination register index
wb_ready  in  1  register file accepts write this cycle
illegal  out  1  one-cycle pulse: rejected instruction
busy  out  1  state != IDLE
retired_cnt  out  CNT_W  count of completed legal instructions

Behaviour:
- Reset (async, active-high): state IDLE; instruction register, rf_rs1, rf_rs2, rf_rd, alu_op and retired_cnt all 0; rf_rd_en, alu_en, rf_wr_en, illegal and busy all 0; instr_ready 1 once reset deasserts.
- States: IDLE -> DECODE -> READ -> EXEC -> WB -> IDLE. An illegal instruction goes DECODE -> IDLE.
- IDLE: instr_ready=1. When instr_valid=1, capture instr and go to DECODE. instr is ignored in every other state.
- DECODE: legal means opcode=0110011 and one of:
  - funct7=0000000 with any funct3;
  - funct7=0100000 with funct3 000 (SUB) or 101 (SRA).
  - Illegal: pulse illegal for exactly this cycle, then go to IDLE. No strobes fire.
- READ: rf_rd_en=1 for one cycle. rf_rs1, rf_rs2 and rf_rd hold the captured fields from DECODE until the next accept.
- EXEC: alu_en=1 for one cycle. alu_op is valid from DECODE onward.
- WB:
  - rd!=0: rf_wr_en=1 and hold WB until wb_ready=1. On that cycle increment retired_cnt and go to IDLE.
  - rd==0: rf_wr_en stays 0; increment retired_cnt and go to IDLE in one cycle, ignoring wb_ready.
- Latency: accept at cycle 0, rf_rd_en at cycle 2, alu_en at cycle 3, rf_wr_en at cycle 4. Minimum 5 cycles per instruction.
- retired_cnt saturates at all-ones and does not wrap.
- flush:
  - In DECODE, READ or EXEC: go to IDLE next cycle. No count, no illegal pulse, no further strobes.
  - In WB or IDLE: ignored. A write already in WB always completes.
- instr_valid held high across completion: the next instruction is accepted only on an IDLE cycle, never in the WB exit cycle.
- Reset asserted mid-instruction: outputs drop to reset values immediately; the instruction is lost.

Decomposition:
- Package rtype_pkg holds:
  - OPC_RTYPE=7'b0110011, F7_BASE=7'b0000000, F7_ALT=7'b0100000;
  - alu_op codes ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9;
  - state enum IDLE/DECODE/READ/EXEC/WB.
- One sub-module, rtype_op_encode: combinational (funct7, funct3, opcode) -> {legal, alu_op}. The FSM and counter stay in rtype_exec_ctrl.

Test Plan:
- Reset mid-READ -> all strobes 0 and retired_cnt=0 immediately; instr_ready=1 after deassert.
- instr=0x004384B3 (add x9,x7,x4), wb_ready=1 -> rf_rd_en cycle 2 with rs1=7, rs2=4; alu_en cycle 3 with alu_op=0; rf_wr_en cycle 4 with rd=9; retired_cnt=1.
- instr=0x40D289B3 (sub x19,x5,x13), wb_ready low 3 cycles -> alu_op=1; rf_wr_en held 4 cycles; count increments once; instr_ready low throughout.
- instr=0x4043D033 (sra x0,x7,x4) -> alu_op=7; rf_wr_en never asserts; retires at cycle 4 regardless of wb_ready.
- instr=0x12345678, then 0x4043F4B3 -> illegal pulses one cycle each at cycle 1; no strobes; retired_cnt unchanged.
- flush during EXEC of a legal op -> no rf_wr_en, no count, IDLE next cycle; a following add accepted normally.
- Preload counter to 2^CNT_W-1 (CNT_W=4: 15 adds), then one more add -> retired_cnt stays 15.
